// File: rtl/dmem_responder_if.sv
// dmem_responder_if -- MEM-stage load/store bus between the pipeline and the
// data-memory responder.
//   req_valid  : MEM stage has a load/store this cycle
//   req_write  : 1 = store, 0 = load
//   req_addr   : byte address
//   req_wdata  : store data
//   req_be     : store byte-lane enables, bit i covers bits [8i+7:8i]
//   mem_stall  : pipeline must hold (combinational)
//   resp_valid : one-cycle completion strobe
//   rdata      : load data, valid while resp_valid=1
//   addr_err   : completion had a misaligned or out-of-range address
// master = pipeline side, slave = memory responder side.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        mem_stall;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        addr_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  mem_stall, resp_valid, rdata, addr_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output mem_stall, resp_valid, rdata, addr_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder -- multi-cycle data-memory responder for the MEM stage.
// Accepts one load/store at a time, stalls the pipeline for LATENCY wait
// cycles, then completes with a one-cycle resp_valid strobe.
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous active-high reset (memory contents untouched)
//   bus    : dmem_responder_if.slave (request in, stall/response out)
// Parameters:
//   ADDR_WIDTH : word-address width, depth = 2^ADDR_WIDTH 32-bit words
//   LATENCY    : wait cycles after acceptance before completion (1..15)
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_responder_if.slave      bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        addr_err_q, addr_err_d;

  logic                  access;   // the edge entering DONE performs the access
  logic                  addr_bad;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           rdata_w;

  // Checks run on the latched request, never on the live bus.
  assign addr_bad = (addr_q[1:0] != 2'b00) ||
                    ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);
  assign word_idx = addr_q[ADDR_WIDTH+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    addr_err_d = addr_err_q;
    access     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!bus.req_valid) begin
          // Pipeline flush: abandon the request without touching memory.
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          access     = 1'b1;
          addr_err_d = addr_bad;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      write_q    <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      addr_err_q <= addr_err_d;
    end
  end

  // One byte-wide RAM per lane so byte enables map onto plain write enables.
  // Each lane has a registered read that is zeroed for stores and errors.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] rd_q;
    logic       we;

    assign we = access && write_q && be_q[gi] && !addr_bad && !reset;

    always_ff @(posedge clk) begin
      if (we) begin
        lane_mem[word_idx] <= wdata_q[8*gi +: 8];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_q <= 8'h00;
      end else if (access) begin
        rd_q <= (!write_q && !addr_bad) ? lane_mem[word_idx] : 8'h00;
      end
    end

    assign rdata_w[8*gi +: 8] = rd_q;
  end

  assign bus.mem_stall  = bus.req_valid && (state_q != DONE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.rdata      = rdata_w;
  assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst1, rst2;
  always #5 clk = ~clk;

  dmem_responder_if b1 ();
  dmem_responder_if b2 ();

  // b2: LATENCY=2 for the main table, b1: LATENCY=1 for back-to-back timing.
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(rst2), .bus(b2.slave)
  );
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(rst1), .bus(b1.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (sel) begin
      b1.req_valid = v; b1.req_write = w; b1.req_addr = a; b1.req_wdata = d; b1.req_be = be;
    end else begin
      b2.req_valid = v; b2.req_write = w; b2.req_addr = a; b2.req_wdata = d; b2.req_be = be;
    end
  endtask

  function automatic logic get_resp(input bit sel);
    return sel ? b1.resp_valid : b2.resp_valid;
  endfunction
  function automatic logic get_stall(input bit sel);
    return sel ? b1.mem_stall : b2.mem_stall;
  endfunction
  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? b1.rdata : b2.rdata;
  endfunction
  function automatic logic get_err(input bit sel);
    return sel ? b1.addr_err : b2.addr_err;
  endfunction

  // Full transaction: hold req_valid until the response, check timing and data.
  task automatic do_req(input bit sel, input int lat, input vec_t v, input string name);
    bit got = 0;
    int cyc = 0;
    int stalls = 0;
    @(posedge clk); #1;
    drive(sel, 1'b1, v.wr, v.addr, v.wdata, v.be);
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (get_resp(sel)) got = 1;
      else begin
        if (get_stall(sel)) stalls++;
        cyc++;
      end
    end
    if (!got) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_resp_cycle"}, 32'(cyc), 32'(lat + 1));
      chk({name, "_stall_cycles"}, 32'(stalls), 32'(lat + 1));
      chk({name, "_stall_done"}, {31'd0, get_stall(sel)}, 32'd0);
      chk({name, "_rdata"}, get_rdata(sel), v.exp_rdata);
      chk({name, "_err"}, {31'd0, get_err(sel)}, {31'd0, v.exp_err});
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk({name, "_resp_one_cycle"}, {31'd0, get_resp(sel)}, 32'd0);
    $display("txn %s: %s addr=0x%08h wdata=0x%08h be=%b rdata=0x%08h err=%0d",
             name, v.wr ? "ST" : "LD", v.addr, v.wdata, v.be, get_rdata(sel), get_err(sel));
  endtask

  initial begin
    vec_t t;
    int resp_seen;
    logic exp_stall [6];
    logic exp_resp  [6];

    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,   32'h11223344, 4'h5, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b0, 32'h12,   32'h0,        4'h0, 32'h0,        1'b1};
    vecs[5]  = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{1'b1, 32'h20,   32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
    vecs[10] = '{1'b1, 32'h20,   32'h00000000, 4'h0, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h20,   32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
    vecs[12] = '{1'b1, 32'h30,   32'h0BADF00D, 4'hF, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'h30,   32'h0,        4'h0, 32'h0BADF00D, 1'b0};

    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    rst1 = 1'b1; rst2 = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    chk("reset_resp", {31'd0, b2.resp_valid}, 32'd0);
    chk("reset_rdata", b2.rdata, 32'd0);
    chk("reset_err", {31'd0, b2.addr_err}, 32'd0);
    chk("reset_stall", {31'd0, b2.mem_stall}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      do_req(1'b0, 2, vecs[i], $sformatf("vec%0d", i));
    end

    // Flush: store to 0x20 abandoned when req_valid drops in cycle 1.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    resp_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b2.resp_valid) resp_seen++;
    end
    chk("flush_no_resp", 32'(resp_seen), 32'd0);
    $display("txn flush: ST addr=0x00000020 dropped, resp_count=%0d", resp_seen);
    t = '{1'b0, 32'h20, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0};
    do_req(1'b0, 2, t, "after_flush");

    // Reset pulse while a store to 0x30 is in BUSY.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h11111111, 4'hF);
    @(posedge clk); #1;
    rst2 = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk); #1;
    rst2 = 1'b0;
    @(negedge clk);
    chk("rst_busy_resp", {31'd0, b2.resp_valid}, 32'd0);
    chk("rst_busy_rdata", b2.rdata, 32'd0);
    chk("rst_busy_err", {31'd0, b2.addr_err}, 32'd0);
    $display("txn reset_in_busy: ST addr=0x00000030 aborted rdata=0x%08h", b2.rdata);
    t = '{1'b0, 32'h30, 32'h0, 4'h0, 32'h0BADF00D, 1'b0};
    do_req(1'b0, 2, t, "after_reset");

    // LATENCY=1: preload, then back-to-back loads with req_valid held high.
    t = '{1'b1, 32'h10, 32'h01020304, 4'hF, 32'h0, 1'b0};
    do_req(1'b1, 1, t, "l1_st10");
    t = '{1'b1, 32'h14, 32'h0A0B0C0D, 4'hF, 32'h0, 1'b0};
    do_req(1'b1, 1, t, "l1_st14");

    exp_stall = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_resp  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_stall_c%0d", c), {31'd0, b1.mem_stall}, {31'd0, exp_stall[c]});
      chk($sformatf("b2b_resp_c%0d", c), {31'd0, b1.resp_valid}, {31'd0, exp_resp[c]});
      if (c == 2) chk("b2b_rdata0", b1.rdata, 32'h01020304);
      if (c == 5) chk("b2b_rdata1", b1.rdata, 32'h0A0B0C0D);
      $display("txn b2b cycle %0d: stall=%0d resp=%0d rdata=0x%08h",
               c, b1.mem_stall, b1.resp_valid, b1.rdata);
      @(posedge clk); #1;
      if (c == 2) drive(1'b1, 1'b1, 1'b0, 32'h14, 32'd0, 4'd0);
      if (c == 5) drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
